vram_arbiter: RTL and testbench

Sequencer and arbiter for the single external 512 KiB video/main SRAM on `va`/`vd`/`n_vrd`/`n_vwr`. It serves four requesters: screen fetch, CPU, a DMA/auxiliary port, and the boot-time ROM-to-RAM initializer. It converts each granted request into a timed SRAM read or write cycle and returns read data with a done strobe. It sits between the requester logic and the SRAM pins and replaces ad-hoc bus steering in the memory controller.

---
 rtl/vram_arbiter_pkg.sv | 29 ++
 rtl/vram_arb_pick.sv | 44 ++++
 rtl/vram_arbiter.sv | 164 ++++++++++++++++
 tb/tb_vram_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arbiter_pkg.sv
// rtl/vram_arbiter_pkg.sv - shared types for the video/main SRAM arbiter
//
// Package common: requester port indices, sequencer states and a small
// one-hot helper used by vram_arbiter and vram_arb_pick.
package common;

    // Requester index; the value is also the bit position in req/gnt/done.
    typedef enum logic [1:0] {
        PORT_SCREEN = 2'd0,
        PORT_CPU    = 2'd1,
        PORT_DMA    = 2'd2,
        PORT_INIT   = 2'd3
    } vram_port_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } vram_state_t;

    function automatic logic [3:0] port_onehot(input vram_port_t p);
        logic [3:0] v;
        v    = 4'b0000;
        v[p] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/vram_arb_pick.sv
// rtl/vram_arb_pick.sv - fixed-priority plus CPU/DMA round-robin winner select
//
// Ports:
//   req[3:0]   request levels (0 screen, 1 CPU, 2 DMA, 3 init)
//   init_busy  masks CPU and DMA while the initializer runs
//   rr_ptr     0 favours CPU, 1 favours DMA when both request
//   win        winning port index (meaningful only when valid)
//   valid      at least one eligible request
// Purely combinational; the pointer register lives in the caller.
module vram_arb_pick
    import common::*;
(
    input  logic [3:0]  req,
    input  logic        init_busy,
    input  logic        rr_ptr,
    output vram_port_t  win,
    output logic        valid
);

    logic cpu_ok;
    logic dma_ok;

    assign cpu_ok = req[PORT_CPU] && !init_busy;
    assign dma_ok = req[PORT_DMA] && !init_busy;

    always_comb begin
        win   = PORT_SCREEN;
        valid = 1'b1;
        if (req[PORT_SCREEN]) begin
            win = PORT_SCREEN;
        end else if (req[PORT_INIT]) begin
            win = PORT_INIT;
        end else if (cpu_ok && dma_ok) begin
            win = rr_ptr ? PORT_DMA : PORT_CPU;
        end else if (cpu_ok) begin
            win = PORT_CPU;
        end else if (dma_ok) begin
            win = PORT_DMA;
        end else begin
            valid = 1'b0;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - four-port arbiter and access sequencer for the external SRAM
//
// Ports:
//   clk28, rst              clock and asynchronous active-high reset
//   init_busy               restricts arbitration to screen and init ports
//   req/addr/we/wdata       per-port request level, address, write flag, data
//   gnt/done                one-cycle accept / completion pulses per port
//   rdata                   read data, valid with the read's done pulse
//   sram_a/sram_dout/sram_doe/sram_din/n_vrd/n_vwr   SRAM pins
//   busy                    sequencer not idle
// Every output is a flop; the output decode below computes next values.
module vram_arbiter
    import common::*;
#(
    parameter int ADDR_W  = 19,
    parameter int WR_HOLD = 1
) (
    input  logic                   clk28,
    input  logic                   rst,
    input  logic                   init_busy,
    input  logic [3:0]             req,
    input  logic [3:0][ADDR_W-1:0] addr,
    input  logic [3:0]             we,
    input  logic [3:0][7:0]        wdata,
    output logic [3:0]             gnt,
    output logic [3:0]             done,
    output logic [7:0]             rdata,
    output logic [ADDR_W-1:0]      sram_a,
    output logic [7:0]             sram_dout,
    output logic                   sram_doe,
    input  logic [7:0]             sram_din,
    output logic                   n_vrd,
    output logic                   n_vwr,
    output logic                   busy
);

    localparam logic HAS_HOLD = (WR_HOLD != 0);

    vram_state_t state;
    vram_state_t state_next;

    logic        rr_ptr;
    vram_port_t  lat_port;
    logic        lat_we;

    vram_port_t  win;
    logic        win_valid;

    logic        last_cycle;
    logic        can_arb;
    logic        turnaround;
    logic        grant;
    logic        we_next;

    logic [3:0]        gnt_d;
    logic [3:0]        done_d;
    logic [7:0]        rdata_d;
    logic [ADDR_W-1:0] sram_a_d;
    logic [7:0]        sram_dout_d;
    logic              sram_doe_d;
    logic              n_vrd_d;
    logic              n_vwr_d;
    logic              busy_d;

    vram_arb_pick u_pick (
        .req       (req),
        .init_busy (init_busy),
        .rr_ptr    (rr_ptr),
        .win       (win),
        .valid     (win_valid)
    );

    // Final cycle of an access: reads end in STROBE, writes in HOLD
    // unless the hold phase is configured out.
    assign last_cycle = ((state == STROBE) && (!lat_we || !HAS_HOLD)) ||
                        (state == HOLD);
    assign can_arb    = (state == IDLE) || last_cycle;

    // Without a hold phase the data bus is still driven in a write's
    // STROBE, so a read may not follow directly; one IDLE cycle is forced.
    assign turnaround = (state == STROBE) && lat_we && !HAS_HOLD;

    assign grant = can_arb && win_valid && !(turnaround && !we[win]);

    // State register
    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = grant ? SETUP : IDLE;
            SETUP:   state_next = STROBE;
            STROBE: begin
                if (lat_we && HAS_HOLD) begin
                    state_next = HOLD;
                end else begin
                    state_next = grant ? SETUP : IDLE;
                end
            end
            HOLD:    state_next = grant ? SETUP : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: next values of the registered outputs
    always_comb begin
        we_next     = grant ? we[win] : lat_we;
        gnt_d       = grant ? port_onehot(win) : 4'b0000;
        done_d      = last_cycle ? port_onehot(lat_port) : 4'b0000;
        rdata_d     = (last_cycle && !lat_we) ? sram_din : rdata;
        sram_a_d    = grant ? addr[win] : sram_a;
        sram_dout_d = grant ? wdata[win] : sram_dout;
        n_vrd_d     = !(((state_next == SETUP) || (state_next == STROBE)) && !we_next);
        n_vwr_d     = !((state_next == STROBE) && we_next);
        sram_doe_d  = we_next && (state_next != IDLE);
        busy_d      = (state_next != IDLE);
    end

    // Output, latch and pointer registers
    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            gnt       <= 4'b0000;
            done      <= 4'b0000;
            rdata     <= 8'h00;
            sram_a    <= '0;
            sram_dout <= 8'h00;
            sram_doe  <= 1'b0;
            n_vrd     <= 1'b1;
            n_vwr     <= 1'b1;
            busy      <= 1'b0;
            rr_ptr    <= 1'b0;
            lat_port  <= PORT_SCREEN;
            lat_we    <= 1'b0;
        end else begin
            gnt       <= gnt_d;
            done      <= done_d;
            rdata     <= rdata_d;
            sram_a    <= sram_a_d;
            sram_dout <= sram_dout_d;
            sram_doe  <= sram_doe_d;
            n_vrd     <= n_vrd_d;
            n_vwr     <= n_vwr_d;
            busy      <= busy_d;
            if (grant) begin
                lat_port <= win;
                lat_we   <= we[win];
                // Pointer moves to whichever of CPU/DMA did not just win.
                if (win == PORT_CPU) begin
                    rr_ptr <= 1'b1;
                end else if (win == PORT_DMA) begin
                    rr_ptr <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed self-checking bench for vram_arbiter
module tb_vram_arbiter;

    localparam int ADDR_W = 19;

    logic                   clk28;
    logic                   rst;
    logic                   init_busy;
    logic [3:0]             req;
    logic [3:0][ADDR_W-1:0] addr;
    logic [3:0]             we;
    logic [3:0][7:0]        wdata;
    logic [3:0]             gnt;
    logic [3:0]             done;
    logic [7:0]             rdata;
    logic [ADDR_W-1:0]      sram_a;
    logic [7:0]             sram_dout;
    logic                   sram_doe;
    logic [7:0]             sram_din;
    logic                   n_vrd;
    logic                   n_vwr;
    logic                   busy;

    int n_pass;
    int n_fail;
    int n_total;

    vram_arbiter #(.ADDR_W(ADDR_W), .WR_HOLD(1)) dut (
        .clk28     (clk28),
        .rst       (rst),
        .init_busy (init_busy),
        .req       (req),
        .addr      (addr),
        .we        (we),
        .wdata     (wdata),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .sram_a    (sram_a),
        .sram_dout (sram_dout),
        .sram_doe  (sram_doe),
        .sram_din  (sram_din),
        .n_vrd     (n_vrd),
        .n_vwr     (n_vwr),
        .busy      (busy)
    );

    // SRAM model: each byte holds its address low byte xor 0xE0.
    assign sram_din = sram_a[7:0] ^ 8'hE0;

    initial clk28 = 1'b0;
    always #18 clk28 = ~clk28;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk28);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Bus-safety invariants sampled away from the active edge.
    always @(negedge clk28) begin
        if (!rst) begin
            check("strobes_overlap", {31'd0, (!n_vrd && !n_vwr)}, 32'd0);
            check("doe_during_read", {31'd0, (sram_doe && !n_vrd)}, 32'd0);
        end
    end

    initial begin
        n_pass = 0; n_fail = 0; n_total = 0;
        rst = 1'b1; init_busy = 1'b0; req = 4'b0000; we = 4'b0000;
        addr = '0; wdata = '0;

        // Reset state
        do_reset();
        check("rst_gnt", gnt, 4'b0000);
        check("rst_done", done, 4'b0000);
        check("rst_nvrd", n_vrd, 1);
        check("rst_nvwr", n_vwr, 1);
        check("rst_doe", sram_doe, 0);
        check("rst_busy", busy, 0);
        check("rst_rdata", rdata, 8'h00);
        check("rst_sram_a", sram_a, 0);

        // Single CPU read
        addr[1] = 19'h12345; req = 4'b0010;
        tick();
        check("rd_gnt", gnt, 4'b0010);
        check("rd_setup_a", sram_a, 19'h12345);
        check("rd_setup_nvrd", n_vrd, 0);
        check("rd_setup_doe", sram_doe, 0);
        check("rd_busy", busy, 1);
        req = 4'b0000; addr[1] = 19'h00000;
        tick();
        check("rd_strobe_gnt", gnt, 4'b0000);
        check("rd_strobe_nvrd", n_vrd, 0);
        check("rd_strobe_a_latched", sram_a, 19'h12345);
        check("rd_strobe_done", done, 4'b0000);
        tick();
        check("rd_done", done, 4'b0010);
        check("rd_rdata", rdata, 8'hA5);
        check("rd_end_nvrd", n_vrd, 1);
        check("rd_end_busy", busy, 0);

        // CPU/DMA alternation, back-to-back reads
        do_reset();
        addr[1] = 19'h00100; addr[2] = 19'h00233; req = 4'b0110;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("rr_gnt_%0d", i), gnt, (i % 2 == 0) ? 4'b0010 : 4'b0100);
            check($sformatf("rr_nvrd_%0d", i), n_vrd, 0);
            if (i > 0) begin
                check($sformatf("rr_done_%0d", i), done, (i % 2 == 1) ? 4'b0010 : 4'b0100);
                check($sformatf("rr_rdata_%0d", i), rdata, (i % 2 == 1) ? 8'hE0 : 8'hD3);
            end
            tick();
            check($sformatf("rr_strobe_gnt_%0d", i), gnt, 4'b0000);
            if (i == 7) req = 4'b0000;
        end
        tick();
        check("rr_last_done", done, 4'b0100);
        check("rr_last_rdata", rdata, 8'hD3);
        check("rr_idle", busy, 0);

        // Screen request during a CPU write
        do_reset();
        addr[1] = 19'h00777; wdata[1] = 8'h5C; we = 4'b0010; req = 4'b0010;
        tick();
        check("wr_gnt", gnt, 4'b0010);
        check("wr_setup_doe", sram_doe, 1);
        check("wr_setup_nvwr", n_vwr, 1);
        check("wr_setup_dout", sram_dout, 8'h5C);
        check("wr_setup_a", sram_a, 19'h00777);
        req = 4'b0000; we = 4'b0000;
        tick();
        check("wr_strobe_nvwr", n_vwr, 0);
        check("wr_strobe_doe", sram_doe, 1);
        addr[0] = 19'h01010; req = 4'b0001;
        tick();
        check("wr_hold_nvwr", n_vwr, 1);
        check("wr_hold_doe", sram_doe, 1);
        check("wr_hold_gnt", gnt, 4'b0000);
        tick();
        check("scr_gnt", gnt, 4'b0001);
        check("wr_done", done, 4'b0010);
        check("scr_setup_doe", sram_doe, 0);
        check("scr_setup_nvrd", n_vrd, 0);
        check("scr_setup_a", sram_a, 19'h01010);
        req = 4'b0000;
        tick();
        tick();
        check("scr_done", done, 4'b0001);
        check("scr_rdata", rdata, 8'hF0);

        // Initializer phase masks CPU and DMA
        do_reset();
        init_busy = 1'b1; addr[3] = 19'h00055; req = 4'b1110;
        tick();
        check("init_gnt_0", gnt, 4'b1000);
        tick();
        tick();
        check("init_gnt_1", gnt, 4'b1000);
        tick();
        init_busy = 1'b0; req = 4'b0110;
        tick();
        check("post_init_gnt", gnt, 4'b0010);
        check("init_done", done, 4'b1000);
        check("init_rdata", rdata, 8'hB5);
        req = 4'b0000;
        tick();
        tick();
        check("post_init_done", done, 4'b0010);

        // Screen beats CPU on simultaneous request
        do_reset();
        addr[0] = 19'h00020; addr[1] = 19'h00030; req = 4'b0011;
        tick();
        check("prio_gnt", gnt, 4'b0001);
        req = 4'b0000;
        tick();
        tick();
        check("prio_done", done, 4'b0001);
        check("prio_rdata", rdata, 8'hC0);

        // Reset during write STROBE
        do_reset();
        addr[1] = 19'h00400; wdata[1] = 8'h77; we = 4'b0010; req = 4'b0010;
        tick();
        req = 4'b0000; we = 4'b0000;
        tick();
        check("mid_strobe_nvwr", n_vwr, 0);
        #5;
        rst = 1'b1;
        #1;
        check("mid_rst_nvwr", n_vwr, 1);
        check("mid_rst_doe", sram_doe, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_dout", sram_dout, 8'h00);
        tick();
        rst = 1'b0;
        tick();
        check("mid_rst_no_done", done, 4'b0000);
        check("mid_rst_idle", busy, 0);
        tick();
        check("mid_rst_no_done2", done, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
